mac_seq_ctrl: RTL

- Sequences one matrix-vector product across a bank of NUM_LANES MAC lanes. Lane i accumulates row i of A against the shared vector B.
- Pulls operands from per-lane A FIFOs and one shared B FIFO, both with registered read data (1-cycle latency).
- Drives broadcast clear/enable to the MAC bank; signals when the bank's accumulator outputs hold the final result.

---
 rtl/mac_seq_pkg.sv | 20 ++
 rtl/mac_seq_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_pkg
// Brief    : Shared types and constants for the MAC sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int PERF_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Brief    : Sequences one matrix-vector product over a bank of MAC lanes.
//            Optional stall counter output enabled by MAC_SEQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LANES-1:0]  a_empty,
    input  logic                  b_empty,
    output logic [NUM_LANES-1:0]  a_rden,
    output logic                  b_rden,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  busy,
`ifdef MAC_SEQ_PERF_EN
    output logic [PERF_CNT_W-1:0] stall_cnt,
`endif
    output logic                  done
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(VEC_LEN - 1);

    generate
        if (VEC_LEN < 1 || DATA_WIDTH < 1) begin : g_bad_param
            $error("mac_seq_ctrl: VEC_LEN and DATA_WIDTH must be >= 1");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_en_q;
    logic             w_go;
    logic             w_rd;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_go        = ~|a_empty & ~b_empty;
        w_rd        = 1'b0;
        mac_clr     = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                mac_clr     = 1'b1;
                w_count_nxt = '0;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_rd = w_go;
                if (w_go) begin
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == c_LAST) w_state_nxt = DRAIN;
                end
            end
            DRAIN: w_state_nxt = DONE;
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort drops any read in flight so the enable pipe never carries it.
        if (abort && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_rd        = 1'b0;
            done        = 1'b0;
        end
    end

    assign a_rden = {NUM_LANES{w_rd}};
    assign b_rden = w_rd;
    assign mac_en = r_en_q;
    assign busy   = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_en_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_en_q  <= w_rd;
        end
    end

`ifdef MAC_SEQ_PERF_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_stall_cnt <= '0;
        end else if (r_state == RUN && !w_go && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
